// File: rtl/led_pio_ctrl.sv
// LED PIO controller: CPU-written pattern with hardware blink, rotate (chaser) and global PWM brightness.
// Latency: a register write shows on leds_export one cycle after it lands; readdata is valid one cycle after read.
// Backpressure: none; the slave never stalls and every access completes in a single cycle.
module led_pio_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 50000
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [2:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] leds_export
);

  localparam int              PS_W    = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_MODE   = 3'd1;
  localparam logic [2:0] A_PERIOD = 3'd2;
  localparam logic [2:0] A_DUTY   = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;

  localparam logic [1:0] MODE_BLINK = 2'd1;
  localparam logic [1:0] MODE_ROTL  = 2'd2;
  localparam logic [1:0] MODE_ROTR  = 2'd3;

  logic [WIDTH-1:0]    data_q, data_d;
  logic [1:0]          mode_q, mode_d;
  logic [15:0]         period_q, period_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                phase_q, phase_d;
  logic [PS_W-1:0]     pre_q, pre_d;
  logic [15:0]         step_q, step_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [WIDTH-1:0]    leds_q, leds_d;
  logic [31:0]         rdata_q, rdata_d;

  logic        tick;
  logic        step_evt;
  logic        pwm_on;
  logic        lit;
  logic [15:0] step_last;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  // Upper writedata bits beyond the widest register are intentionally ignored.
  assign unused_wdata = ^writedata;

  // A PERIOD of zero behaves as one tick per step.
  assign tick      = (pre_q == PS_LAST);
  assign step_last = (period_q == 16'd0) ? 16'd0 : period_q - 16'd1;
  assign step_evt  = tick && (step_q == step_last);
  assign pwm_on    = (pwm_q < duty_q) || (&duty_q);
  assign lit       = pwm_on && ((mode_q != MODE_BLINK) || phase_q);

  // Next-state: counters and animation first, then bus writes override (a write beats a coincident step).
  always_comb begin
    data_d   = data_q;
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    phase_d  = phase_q;
    pre_d    = tick ? '0 : pre_q + 1'b1;
    step_d   = step_q;
    pwm_d    = pwm_q + 1'b1;
    if (tick) begin
      step_d = step_evt ? 16'd0 : step_q + 16'd1;
    end
    if (step_evt) begin
      case (mode_q)
        MODE_BLINK: phase_d = ~phase_q;
        MODE_ROTL:  data_d  = (data_q << 1) | (data_q >> (WIDTH - 1));
        MODE_ROTR:  data_d  = (data_q >> 1) | (data_q << (WIDTH - 1));
        default:    ;
      endcase
    end
    if (write) begin
      case (address)
        A_DATA: begin
          data_d  = writedata[WIDTH-1:0];
          pre_d   = '0;
          step_d  = 16'd0;
          phase_d = 1'b1;
        end
        A_MODE: begin
          mode_d  = writedata[1:0];
          data_d  = data_q;
          pre_d   = '0;
          step_d  = 16'd0;
          phase_d = 1'b1;
        end
        A_PERIOD: period_d = writedata[15:0];
        A_DUTY:   duty_d   = writedata[PWM_BITS-1:0];
        default:  ;
      endcase
    end
  end

  // Read mux samples pre-write state so a same-cycle read+write returns the old value.
  always_comb begin
    rd_mux = 32'd0;
    case (address)
      A_DATA:   rd_mux[WIDTH-1:0]    = data_q;
      A_MODE:   rd_mux[1:0]          = mode_q;
      A_PERIOD: rd_mux[15:0]         = period_q;
      A_DUTY:   rd_mux[PWM_BITS-1:0] = duty_q;
      A_STATUS: rd_mux               = {step_q, 15'd0, phase_q};
      default:  rd_mux               = 32'd0;
    endcase
    rdata_d = read ? rd_mux : rdata_q;
    leds_d  = data_q & {WIDTH{lit}};
  end

  // State registers; reset clears everything immediately regardless of activity.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      data_q   <= '0;
      mode_q   <= 2'd0;
      period_q <= 16'd1;
      duty_q   <= '1;
      phase_q  <= 1'b1;
      pre_q    <= '0;
      step_q   <= 16'd0;
      pwm_q    <= '0;
      leds_q   <= '0;
      rdata_q  <= 32'd0;
    end else begin
      data_q   <= data_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      phase_q  <= phase_d;
      pre_q    <= pre_d;
      step_q   <= step_d;
      pwm_q    <= pwm_d;
      leds_q   <= leds_d;
      rdata_q  <= rdata_d;
    end
  end

  assign leds_export = leds_q;
  assign readdata    = rdata_q;

endmodule

// File: doc/led_pio_ctrl.md
# led_pio_ctrl

Parametrised Avalon-MM LED output peripheral, successor to the fixed 8-bit `leds_export` PIO in the `nios2hps` Qsys system. It drives `WIDTH` LEDs from a CPU-written pattern and adds hardware blink, rotate (chaser) and global PWM brightness. The LEDs therefore animate without Nios II or HPS software intervention. It sits on the lightweight Avalon bus as a slave, and its `leds_export` conduit goes to the board LEDs.

## Interface
Parameters:
- `WIDTH`, default 8: number of LEDs, 1..32.
- `PWM_BITS`, default 8: PWM counter and duty width, 1..16.
- `PRESCALE`, default 50000: clock cycles per time tick, ≥2.

Ports:
- `clk_clk`  in  1  single system clock.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  3  word address.
- `read`  in  1  read strobe.
- `write`  in  1  write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  read data, fixed read latency 1, no waitrequest.
- `leds_export`  out  `WIDTH`  registered LED drive, 1 = lit.

## Operation
Registers; unused bits read 0:
- 0 DATA (RW) [WIDTH-1:0]: pattern register. A write loads the pattern, clears the tick prescaler and step counter, and sets phase=1. A read returns the current (possibly rotated) pattern.
- 1 MODE (RW) [1:0]:
  - 0 static.
  - 1 blink: the whole pattern is gated by phase.
  - 2 rotate left.
  - 3 rotate right.
  - A write clears the prescaler and step counter and sets phase=1.
- 2 PERIOD (RW) [15:0]: ticks per step. A value of 0 behaves as 1.
- 3 DUTY (RW) [PWM_BITS-1:0]: global brightness.
- 4 STATUS (RO): [0] phase, [31:16] step counter.
- Addresses 5–7: reads return 0, writes are ignored.

Counters:
- Prescaler runs 0..PRESCALE-1. `tick` asserts for one cycle when the prescaler equals PRESCALE-1, then the prescaler wraps to 0.
- Step counter advances on `tick`. Step event = `tick` && step counter == max(PERIOD,1)-1, after which the step counter wraps to 0.
- On a step event:
  - mode 1: phase toggles.
  - mode 2: pattern rotates left by 1 (bit WIDTH-1 → bit 0).
  - mode 3: pattern rotates right by 1.
  - mode 0: no effect.
- PWM counter is free-running over PWM_BITS, wrapping at all-ones → 0.
  - `pwm_on` = (pwm_cnt < DUTY) || (DUTY == all-ones).
  - DUTY=0 gives LEDs always dark.

Output, registered:
- `leds_export` ← pattern & {WIDTH{pwm_on && (MODE!=1 || phase)}}.

Arithmetic and precedence:
- All counters are unsigned and wrap.
- A DATA write in the same cycle as a step event: the write wins and no rotate is applied.
- A MODE write in the same cycle as a step event: the write wins and the step is discarded.
- Simultaneous `read` and `write` to the same address: `readdata` returns the pre-write value.

## Timing
- Reset values:
  - `leds_export`=0, `readdata`=0.
  - DATA=0, MODE=0, PERIOD=1, DUTY=all-ones.
  - phase=1, all counters 0.
- Reset assertion clears every register immediately, whether or not an animation or bus cycle is in progress. The first edge after deassertion is a normal counting edge.
- Write accepted at edge N: the register holds the new value after N, and `leds_export` reflects it after edge N+1 (one-cycle output latency).
- Read with `read` high at edge N: `readdata` is valid after edge N and held until the next read. `readdata` is not cleared when `read` is low.
- Step event at edge N: the pattern or phase changes at N, and `leds_export` changes at N+1.
- Blink half-period = max(PERIOD,1)·PRESCALE cycles. Rotate step period is the same.

## Test plan
Bench overrides PRESCALE=4, PWM_BITS=4, WIDTH=8.
- **Reset state:** hold reset, then release → `leds_export`=0x00; read DUTY=0xF, PERIOD=1, MODE=0.
- **Static write latency:** write DATA=0xA5 at edge N → `leds_export`=0xA5 from edge N+1; read DATA=0xA5 one cycle later.
- **Rotate left:**
  - Setup: DATA=0x81, PERIOD=2, MODE=2.
  - Every 8 cycles the pattern steps 0x81 → 0x03 → 0x06 → …; after 8 steps it returns to 0x81.
  - A DATA write coincident with a step event leaves the written value unrotated.
- **Blink:**
  - Setup: DATA=0xFF, MODE=1, PERIOD=0.
  - `leds_export` alternates 0xFF/0x00 every 4 cycles, starting lit.
  - STATUS[0] follows phase.
  - A MODE write mid-period restarts with phase=1.
- **PWM:** DATA=0x0F, DUTY=3 → per 16-cycle window, `leds_export`=0x0F for exactly 3 cycles and 0x00 for 13. DUTY=0 gives always 0; DUTY=0xF gives always 0x0F.
- **Reset mid-animation:** assert `reset_reset_n` low asynchronously during rotate mode → `leds_export` goes 0 without a clock edge; after release the block is static with DATA=0.
